ctrl: RTL and testbench
=======================

Name: ctrl

Overview:
- Main control unit of the single-cycle MIPS-style processor.
- Decodes the 6-bit instruction opcode into datapath control strobes (register file, ALU source, memory, branch, jump) and the ALU selection pair ALUTipoR/ALUnaoR consumed by the ALU control.
- Decode is purely combinational, so control is valid in the same cycle as the instruction.
- A small clocked status section records illegal opcodes.

Parameters:
- none

Ports:
- clk  input  1  system clock; clocks only the status register.
- rst  input  1  synchronous, active-high reset.
- OPCode  input  6  instruction bits [31:26].
- RegDst  output  1  1 = write register is rd; 0 = rt.
- Branch  output  1  conditional branch (beq).
- MemRead  output  1  data memory read enable.
- MemtoReg  output  1  1 = write-back data from memory; 0 = from ALU.
- MemWrite  output  1  data memory write enable.
- ALUSrc  output  1  1 = ALU operand B is the extended immediate; 0 = rt.
- RegWrite  output  1  register file write enable.
- Jump  output  1  PC takes the jump target.
- ALUTipoR  output  1  1 = ALU control decodes the funct field.
- ALUnaoR  output  4  ALU operation when ALUTipoR=0.
- ZeroExt  output  1  1 = zero-extend the immediate; 0 = sign-extend.
- Link  output  1  jal: write PC+4 to $31.
- Illegal  output  1  current opcode is not supported.
- IllegalSeen  output  1  sticky flag: an illegal opcode was sampled since reset.

Behaviour:
- Control outputs are combinational functions of OPCode only. No latency; they are unaffected by clk and rst.
- ALUnaoR codes: 0 = AND, 1 = OR, 2 = ADD, 3 = XOR, 6 = SUB, 7 = SLT.
- Decode table. Signals not listed are 0 and ALUnaoR is 4'h0.
  - 000000 R-type: RegDst, RegWrite, ALUTipoR = 1. ALUnaoR = 0, don't-care for the ALU.
  - 100011 lw: ALUSrc, MemRead, MemtoReg, RegWrite = 1; ALUnaoR = 2.
  - 101011 sw: ALUSrc, MemWrite = 1; ALUnaoR = 2.
  - 000100 beq: Branch = 1; ALUnaoR = 6.
  - 001000 addi: ALUSrc, RegWrite = 1; ALUnaoR = 2.
  - 001100 andi: ALUSrc, RegWrite, ZeroExt = 1; ALUnaoR = 0.
  - 001101 ori: ALUSrc, RegWrite, ZeroExt = 1; ALUnaoR = 1.
  - 001110 xori: ALUSrc, RegWrite, ZeroExt = 1; ALUnaoR = 3.
  - 001010 slti: ALUSrc, RegWrite = 1; ALUnaoR = 7.
  - 000010 j: Jump = 1.
  - 000011 jal: Jump, RegWrite, Link = 1.
- Any other opcode:
  - All strobes, including RegWrite, MemWrite, Branch and Jump, are 0, so the instruction acts as a no-op.
  - ALUnaoR = 0 and Illegal = 1.
- No output is ever X or Z for any 6-bit input.
- IllegalSeen register, updated on the clk rising edge:
  - rst = 1 → 0 (reset has priority over a simultaneous illegal opcode).
  - Otherwise, IllegalSeen <= IllegalSeen | Illegal.
  - Once set, it stays set until rst.
  - Its value after reset is 0.

Test Plan:
- OPCode = 000000 → ALUTipoR = 1, RegDst = 1, RegWrite = 1, MemRead = 0, MemWrite = 0, Branch = 0, Jump = 0, ALUnaoR = 0.
- OPCode = 100011 → ALUTipoR = 0, ALUnaoR = 2, MemRead = 1, MemtoReg = 1, RegWrite = 1, ALUSrc = 1, RegDst = 0.
- OPCode = 000100 → ALUnaoR = 6, Branch = 1, RegWrite = 0.
- OPCode = 001100 → ALUnaoR = 0, RegWrite = 1, ZeroExt = 1.
- OPCode = 000010 → Jump = 1, RegWrite = 0. OPCode = 000011 → Jump = 1, Link = 1, RegWrite = 1.
- Illegal sticky flag:
  - Apply rst = 1 for one edge → IllegalSeen = 0.
  - Apply OPCode = 111111 → Illegal = 1 immediately, all strobes 0.
  - After the next clk edge → IllegalSeen = 1; it stays 1 with OPCode back at 000000.
  - Assert rst with 111111 still applied → IllegalSeen = 0 after the edge.
- Sweep all 64 opcodes → outputs match the table, Illegal = 1 exactly for the 53 unlisted codes.

Source files
------------

// File: rtl/ctrl.sv
// Main control unit: decodes the instruction opcode into datapath strobes and
// the ALU selection pair, and keeps a sticky record of illegal opcodes.
module ctrl (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] OPCode,
   output logic       RegDst,
   output logic       Branch,
   output logic       MemRead,
   output logic       MemtoReg,
   output logic       MemWrite,
   output logic       ALUSrc,
   output logic       RegWrite,
   output logic       Jump,
   output logic       ALUTipoR,
   output logic [3:0] ALUnaoR,
   output logic       ZeroExt,
   output logic       Link,
   output logic       Illegal,
   output logic       IllegalSeen
);

   localparam logic [5:0] OpRType = 6'b000000;
   localparam logic [5:0] OpLw    = 6'b100011;
   localparam logic [5:0] OpSw    = 6'b101011;
   localparam logic [5:0] OpBeq   = 6'b000100;
   localparam logic [5:0] OpAddi  = 6'b001000;
   localparam logic [5:0] OpAndi  = 6'b001100;
   localparam logic [5:0] OpOri   = 6'b001101;
   localparam logic [5:0] OpXori  = 6'b001110;
   localparam logic [5:0] OpSlti  = 6'b001010;
   localparam logic [5:0] OpJ     = 6'b000010;
   localparam logic [5:0] OpJal   = 6'b000011;

   localparam logic [3:0] AluAnd = 4'h0;
   localparam logic [3:0] AluOr  = 4'h1;
   localparam logic [3:0] AluAdd = 4'h2;
   localparam logic [3:0] AluXor = 4'h3;
   localparam logic [3:0] AluSub = 4'h6;
   localparam logic [3:0] AluSlt = 4'h7;

   // Opcode decode; unsupported codes leave every strobe low so they act as no-ops.
   always_comb begin
      RegDst   = 1'b0;
      Branch   = 1'b0;
      MemRead  = 1'b0;
      MemtoReg = 1'b0;
      MemWrite = 1'b0;
      ALUSrc   = 1'b0;
      RegWrite = 1'b0;
      Jump     = 1'b0;
      ALUTipoR = 1'b0;
      ALUnaoR  = AluAnd;
      ZeroExt  = 1'b0;
      Link     = 1'b0;
      Illegal  = 1'b0;
      case (OPCode)
         OpRType: begin
            RegDst   = 1'b1;
            RegWrite = 1'b1;
            ALUTipoR = 1'b1;
         end
         OpLw: begin
            ALUSrc   = 1'b1;
            MemRead  = 1'b1;
            MemtoReg = 1'b1;
            RegWrite = 1'b1;
            ALUnaoR  = AluAdd;
         end
         OpSw: begin
            ALUSrc   = 1'b1;
            MemWrite = 1'b1;
            ALUnaoR  = AluAdd;
         end
         OpBeq: begin
            Branch  = 1'b1;
            ALUnaoR = AluSub;
         end
         OpAddi: begin
            ALUSrc   = 1'b1;
            RegWrite = 1'b1;
            ALUnaoR  = AluAdd;
         end
         OpAndi: begin
            ALUSrc   = 1'b1;
            RegWrite = 1'b1;
            ZeroExt  = 1'b1;
            ALUnaoR  = AluAnd;
         end
         OpOri: begin
            ALUSrc   = 1'b1;
            RegWrite = 1'b1;
            ZeroExt  = 1'b1;
            ALUnaoR  = AluOr;
         end
         OpXori: begin
            ALUSrc   = 1'b1;
            RegWrite = 1'b1;
            ZeroExt  = 1'b1;
            ALUnaoR  = AluXor;
         end
         OpSlti: begin
            ALUSrc   = 1'b1;
            RegWrite = 1'b1;
            ALUnaoR  = AluSlt;
         end
         OpJ: begin
            Jump = 1'b1;
         end
         OpJal: begin
            Jump     = 1'b1;
            RegWrite = 1'b1;
            Link     = 1'b1;
         end
         default: begin
            Illegal = 1'b1;
         end
      endcase
   end

   // Sticky illegal-opcode flag; reset wins over a coincident illegal opcode.
   always_ff @(posedge clk) begin
      if (rst) begin
         IllegalSeen <= 1'b0;
      end else begin
         IllegalSeen <= IllegalSeen | Illegal;
      end
   end

endmodule

// File: tb/tb_ctrl.sv
// Self-checking bench for ctrl: table-driven reference model of the decode and
// of the sticky illegal flag, directed cases plus random opcode/reset traffic.
module tb_ctrl;

   logic       clk;
   logic       rst;
   logic [5:0] OPCode;
   logic       RegDst, Branch, MemRead, MemtoReg, MemWrite, ALUSrc;
   logic       RegWrite, Jump, ALUTipoR, ZeroExt, Link, Illegal, IllegalSeen;
   logic [3:0] ALUnaoR;

   int checks;
   int failures;

   // Reference decode table, one 16-bit vector per opcode:
   // {RegDst,Branch,MemRead,MemtoReg,MemWrite,ALUSrc,RegWrite,Jump,ALUTipoR,ALUnaoR[3:0],ZeroExt,Link,Illegal}
   logic [15:0] refTbl [64];
   logic        modelSeen;

   ctrl dut (
      .clk(clk), .rst(rst), .OPCode(OPCode),
      .RegDst(RegDst), .Branch(Branch), .MemRead(MemRead), .MemtoReg(MemtoReg),
      .MemWrite(MemWrite), .ALUSrc(ALUSrc), .RegWrite(RegWrite), .Jump(Jump),
      .ALUTipoR(ALUTipoR), .ALUnaoR(ALUnaoR), .ZeroExt(ZeroExt), .Link(Link),
      .Illegal(Illegal), .IllegalSeen(IllegalSeen)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model of the sticky flag, sampled on the same edge as the DUT.
   always @(posedge clk) begin
      if (rst) modelSeen <= 1'b0;
      else     modelSeen <= modelSeen | refTbl[OPCode][0];
   end

   function automatic logic [15:0] mk(input logic rd, br, mr, m2r, mw, src, rw, jmp, tr,
                                      input logic [3:0] alu, input logic ze, lk, ill);
      return {rd, br, mr, m2r, mw, src, rw, jmp, tr, alu, ze, lk, ill};
   endfunction

   function automatic logic [15:0] dutVec();
      return {RegDst, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, Jump,
              ALUTipoR, ALUnaoR, ZeroExt, Link, Illegal};
   endfunction

   task automatic buildTable();
      for (int i = 0; i < 64; i++) refTbl[i] = mk(0,0,0,0,0,0,0,0,0, 4'd0, 0,0,1);
      refTbl[6'b000000] = mk(1,0,0,0,0,0,1,0,1, 4'd0, 0,0,0);
      refTbl[6'b100011] = mk(0,0,1,1,0,1,1,0,0, 4'd2, 0,0,0);
      refTbl[6'b101011] = mk(0,0,0,0,1,1,0,0,0, 4'd2, 0,0,0);
      refTbl[6'b000100] = mk(0,1,0,0,0,0,0,0,0, 4'd6, 0,0,0);
      refTbl[6'b001000] = mk(0,0,0,0,0,1,1,0,0, 4'd2, 0,0,0);
      refTbl[6'b001100] = mk(0,0,0,0,0,1,1,0,0, 4'd0, 1,0,0);
      refTbl[6'b001101] = mk(0,0,0,0,0,1,1,0,0, 4'd1, 1,0,0);
      refTbl[6'b001110] = mk(0,0,0,0,0,1,1,0,0, 4'd3, 1,0,0);
      refTbl[6'b001010] = mk(0,0,0,0,0,1,1,0,0, 4'd7, 0,0,0);
      refTbl[6'b000010] = mk(0,0,0,0,0,0,0,1,0, 4'd0, 0,0,0);
      refTbl[6'b000011] = mk(0,0,0,0,0,0,1,1,0, 4'd0, 0,1,0);
   endtask

   // Inputs change just after the falling edge; outputs settle before the next rise.
   task automatic drive(input logic [5:0] op, input logic r);
      @(negedge clk);
      OPCode = op;
      rst    = r;
      #1;
   endtask

   task automatic test_reset();
      drive(6'b111111, 1'b1);
      @(posedge clk);
      #1;
      checks++;
      if (IllegalSeen !== 1'b0) begin
         failures++;
         $display("FAIL reset_illegalSeen got=%b exp=0", IllegalSeen);
      end
   endtask

   task automatic test_plan_decode();
      drive(6'b000000, 1'b0);
      checks++;
      if ({ALUTipoR, RegDst, RegWrite, MemRead, MemWrite, Branch, Jump, ALUnaoR} !== {7'b1110000, 4'd0}) begin
         failures++;
         $display("FAIL plan_rtype got=%h exp=%h", dutVec(), refTbl[6'b000000]);
      end
      drive(6'b100011, 1'b0);
      checks++;
      if ({ALUTipoR, ALUnaoR, MemRead, MemtoReg, RegWrite, ALUSrc, RegDst} !== {1'b0, 4'd2, 5'b11110}) begin
         failures++;
         $display("FAIL plan_lw got=%h exp=%h", dutVec(), refTbl[6'b100011]);
      end
      drive(6'b000100, 1'b0);
      checks++;
      if ({ALUnaoR, Branch, RegWrite} !== {4'd6, 2'b10}) begin
         failures++;
         $display("FAIL plan_beq got=%h exp=%h", dutVec(), refTbl[6'b000100]);
      end
      drive(6'b001100, 1'b0);
      checks++;
      if ({ALUnaoR, RegWrite, ZeroExt} !== {4'd0, 2'b11}) begin
         failures++;
         $display("FAIL plan_andi got=%h exp=%h", dutVec(), refTbl[6'b001100]);
      end
      drive(6'b000010, 1'b0);
      checks++;
      if ({Jump, RegWrite} !== 2'b10) begin
         failures++;
         $display("FAIL plan_j got=%h exp=%h", dutVec(), refTbl[6'b000010]);
      end
      drive(6'b000011, 1'b0);
      checks++;
      if ({Jump, Link, RegWrite} !== 3'b111) begin
         failures++;
         $display("FAIL plan_jal got=%h exp=%h", dutVec(), refTbl[6'b000011]);
      end
   endtask

   task automatic test_sticky();
      drive(6'b000000, 1'b1);
      @(posedge clk);
      #1;
      checks++;
      if (IllegalSeen !== 1'b0) begin
         failures++;
         $display("FAIL sticky_cleared got=%b exp=0", IllegalSeen);
      end
      drive(6'b111111, 1'b0);
      checks++;
      if (dutVec() !== 16'h0001 || IllegalSeen !== 1'b0) begin
         failures++;
         $display("FAIL sticky_illegal_comb got=%h/%b exp=0001/0", dutVec(), IllegalSeen);
      end
      drive(6'b000000, 1'b0);
      checks++;
      if (IllegalSeen !== 1'b1 || Illegal !== 1'b0) begin
         failures++;
         $display("FAIL sticky_set got=%b/%b exp=1/0", IllegalSeen, Illegal);
      end
      for (int i = 0; i < 3; i++) begin
         drive(6'b000000, 1'b0);
         checks++;
         if (IllegalSeen !== 1'b1) begin
            failures++;
            $display("FAIL sticky_hold cycle=%0d got=%b exp=1", i, IllegalSeen);
         end
      end
      drive(6'b111111, 1'b1);
      @(posedge clk);
      #1;
      checks++;
      if (IllegalSeen !== 1'b0) begin
         failures++;
         $display("FAIL sticky_reset_priority got=%b exp=0", IllegalSeen);
      end
   endtask

   task automatic test_sweep();
      int nIllegal;
      nIllegal = 0;
      for (int op = 0; op < 64; op++) begin
         drive(6'(op), 1'b1);
         if (Illegal === 1'b1) nIllegal++;
         checks++;
         if (dutVec() !== refTbl[op]) begin
            failures++;
            $display("FAIL sweep op=%b got=%h exp=%h", 6'(op), dutVec(), refTbl[op]);
         end
         checks++;
         if ($isunknown({dutVec(), IllegalSeen})) begin
            failures++;
            $display("FAIL sweep_xz op=%b got=%h", 6'(op), dutVec());
         end
      end
      checks++;
      if (nIllegal != 53) begin
         failures++;
         $display("FAIL sweep_illegal_count got=%0d exp=53", nIllegal);
      end
   endtask

   task automatic test_random();
      logic [5:0] op;
      logic       r;
      for (int i = 0; i < 300; i++) begin
         // Bias toward legal codes so the flag is exercised both ways.
         if ($urandom_range(0, 1) == 0) op = 6'($urandom_range(0, 63));
         else begin
            case ($urandom_range(0, 3))
               0: op = 6'b000000;
               1: op = 6'b100011;
               2: op = 6'b001110;
               default: op = 6'b000011;
            endcase
         end
         r = ($urandom_range(0, 15) == 0);
         drive(op, r);
         checks++;
         if (dutVec() !== refTbl[op]) begin
            failures++;
            $display("FAIL random_decode i=%0d op=%b got=%h exp=%h", i, op, dutVec(), refTbl[op]);
         end
         checks++;
         if (IllegalSeen !== modelSeen) begin
            failures++;
            $display("FAIL random_illegalSeen i=%0d got=%b exp=%b", i, IllegalSeen, modelSeen);
         end
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      OPCode   = 6'b000000;
      buildTable();
      test_reset();
      test_plan_decode();
      test_sticky();
      test_sweep();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
